// File: rtl/timer_bank_pkg.sv
// rtl/timer_bank_pkg.sv - register map constants shared by timer_bank and timer_channel
// Contents: per-channel register selector (input_addr[3:2]), CTRL/STATUS bit
// positions and the byte address of the global prescaler register.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        REG_LOAD   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AUTO_BIT  = 1;
    localparam int STATUS_EXP_BIT = 0;

    localparam logic [31:0] PRESC_ADDR = 32'h0000_0040;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counting timer channel with expiry pulse
// Ports: clk, rst (sync, active-high), tick (count enable), wr_load/wr_ctrl/
// wr_status (decoded write strobes), wdata (write payload), load/count/en/auto/
// exp (register readback), done (one-cycle expiry pulse, one cycle after expiry).
import timer_bank_pkg::*;

module timer_channel #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr_load,
    input  logic             wr_ctrl,
    input  logic             wr_status,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] load,
    output logic [CNT_W-1:0] count,
    output logic             en,
    output logic             auto,
    output logic             exp,
    output logic             done
);

    logic exp_pend;
    logic expire_now;

    // A CTRL write owns COUNT on its edge, so it also suppresses that edge's expiry.
    assign expire_now = tick && en && (count == '0) && !wr_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            load     <= '0;
            count    <= '0;
            en       <= 1'b0;
            auto     <= 1'b0;
            exp      <= 1'b0;
            exp_pend <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Expiry is captured first, then presented on done one cycle later.
            exp_pend <= expire_now;
            done     <= exp_pend;

            if (wr_load) begin
                load <= wdata;
            end

            if (wr_ctrl) begin
                en   <= wdata[CTRL_EN_BIT];
                auto <= wdata[CTRL_AUTO_BIT];
                if (wdata[CTRL_EN_BIT]) begin
                    count <= load;
                end
            end else if (tick && en) begin
                if (count != '0) begin
                    count <= count - 1'b1;
                end else if (auto) begin
                    count <= load;
                end else begin
                    en <= 1'b0;
                end
            end

            // Expiry wins over a same-cycle write-1-to-clear.
            if (expire_now) begin
                exp <= 1'b1;
            end else if (wr_status && wdata[STATUS_EXP_BIT]) begin
                exp <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of NUM_CH timer channels behind a simple register port
// Ports: clk, rst (sync, active-high), input_addr (byte address), write_enable,
// write_data, read_data (registered, 1-cycle latency), done[NUM_CH-1:0].
// Build option: TIMER_BANK_PRESCALE_EN adds the PRESC register at 0x40 and a
// shared prescaler; without it every clk cycle is a tick and 0x40 is invalid.
import timer_bank_pkg::*;

module timer_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       input_addr,
    input  logic              write_enable,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic [NUM_CH-1:0] done
);

    logic       addr_ok;
    logic [1:0] ch_sel;
    reg_sel_e   reg_sel;
    logic       tick;
    logic [31:0] rdata_next;
    logic       unused_addr_lsb;

    logic [CNT_W-1:0] load_v  [NUM_CH];
    logic [CNT_W-1:0] count_v [NUM_CH];
    logic             en_v    [NUM_CH];
    logic             auto_v  [NUM_CH];
    logic             exp_v   [NUM_CH];

    assign addr_ok         = (input_addr[31:6] == '0);
    assign ch_sel          = input_addr[5:4];
    assign reg_sel         = reg_sel_e'(input_addr[3:2]);
    assign unused_addr_lsb = ^input_addr[1:0];

`ifdef TIMER_BANK_PRESCALE_EN
    logic [7:0] presc;
    logic [7:0] presc_cnt;
    logic       presc_hit;

    assign presc_hit = (input_addr[31:2] == PRESC_ADDR[31:2]);
    assign tick      = (presc_cnt == presc);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            presc_cnt <= '0;
        end else if (write_enable && presc_hit) begin
            presc     <= write_data[7:0];
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic sel_ch;
        assign sel_ch = write_enable && addr_ok && (ch_sel == 2'(g));

        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .wr_load   (sel_ch && (reg_sel == REG_LOAD)),
            .wr_ctrl   (sel_ch && (reg_sel == REG_CTRL)),
            .wr_status (sel_ch && (reg_sel == REG_STATUS)),
            .wdata     (write_data[CNT_W-1:0]),
            .load      (load_v[g]),
            .count     (count_v[g]),
            .en        (en_v[g]),
            .auto      (auto_v[g]),
            .exp       (exp_v[g]),
            .done      (done[g])
        );
    end

    always_comb begin
        rdata_next = '0;
        if (addr_ok) begin
            case (reg_sel)
                REG_LOAD:   rdata_next = 32'(load_v[ch_sel]);
                REG_COUNT:  rdata_next = 32'(count_v[ch_sel]);
                REG_CTRL:   begin
                    rdata_next[CTRL_EN_BIT]   = en_v[ch_sel];
                    rdata_next[CTRL_AUTO_BIT] = auto_v[ch_sel];
                end
                REG_STATUS: rdata_next[STATUS_EXP_BIT] = exp_v[ch_sel];
                default:    rdata_next = '0;
            endcase
        end
`ifdef TIMER_BANK_PRESCALE_EN
        if (presc_hit) begin
            rdata_next = {24'd0, presc};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else begin
            read_data <= rdata_next;
        end
    end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of timer channels; the only supported value is 4, to match the interrupt controller's done[3:0].
REQ-002 SHALL have parameter CNT_W, default 32, counter and LOAD width in bits.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port input_addr, input, 32 bits: register byte address; bits [1:0] ignored.
REQ-007 SHALL have port write_enable, input, 1 bit: write strobe, one write per cycle.
REQ-008 SHALL have port write_data, input, 32 bits: write payload.
REQ-009 SHALL have port read_data, output, 32 bits: registered read payload.
REQ-010 SHALL have port done, output, NUM_CH bits: per-channel expiry pulse, feeds the interrupt controller's done input.

Function
REQ-011 SHALL decode the channel from input_addr[5:4] and the register from input_addr[3:2]: 0 LOAD (RW), 1 COUNT (RO), 2 CTRL (RW; bit0 EN, bit1 AUTO), 3 STATUS (bit0 EXP, write-1-to-clear).
REQ-012 SHALL, for any address with input_addr[31:6] nonzero, return 0 on read and ignore writes.
REQ-013 SHALL present read data one cycle after input_addr is applied (registered, 1-cycle latency); reads have no side effects.
REQ-014 SHALL, on a CTRL write with EN=1, load COUNT from LOAD on the same clock edge (arm), even when the channel is already running (re-arm).
REQ-015 SHALL, on a CTRL write with EN=0, freeze COUNT at its current value and emit no further pulses.
REQ-016 SHALL, per tick while EN=1 and COUNT!=0, decrement COUNT by 1.
REQ-017 SHALL, per tick while EN=1 and COUNT==0 (expiry), assert done[ch] for exactly one clk cycle on the following cycle and set STATUS.EXP.
REQ-018 SHALL, on expiry with AUTO=1, reload COUNT from LOAD with EN remaining 1; with AUTO=0 it SHALL clear EN and hold COUNT at 0.
REQ-019 SHALL, with LOAD=0 and AUTO=1, expire on every tick.
REQ-020 SHALL apply a LOAD write only at the next arm or reload, never to a running COUNT.
REQ-021 SHALL give expiry priority when expiry and a STATUS write-1-to-clear occur in the same cycle, leaving EXP=1.
REQ-022 SHALL treat channels independently; simultaneous expiries assert several done bits in the same cycle.
REQ-023 SHALL define a tick as every clk cycle when TIMER_BANK_PRESCALE_EN is undefined.

Reset
REQ-024 SHALL on rst clear LOAD, COUNT, CTRL, STATUS, done and read_data to 0 on that edge.
REQ-025 SHALL let rst abort an in-flight count or a pending done pulse, with no pulse emitted after rst is sampled high.

Configuration
REQ-026 SHALL, when TIMER_BANK_PRESCALE_EN is defined, add a global register at byte address 0x40 (bits [7:0] PRESC, reset 0); a tick occurs every PRESC+1 clk cycles from a shared free-running prescaler that is cleared by rst and by any write to 0x40.
REQ-027 SHALL, when TIMER_BANK_PRESCALE_EN is undefined, omit the prescaler and treat address 0x40 as invalid per REQ-012.

Structure
REQ-028 SHALL place register offsets, CTRL/STATUS bit positions and the PRESC address in package timer_bank_pkg.
REQ-029 SHALL implement one sub-module, timer_channel, instantiated NUM_CH times, holding LOAD/COUNT/CTRL/STATUS and the done pulse logic; timer_bank holds decode, the read mux and the prescaler.

Verification
REQ-030 SHALL test one-shot: ch0 LOAD=5, CTRL=0x1 -> done[0] high for 1 cycle, 7 cycles after the CTRL write edge; CTRL then reads 0, COUNT reads 0 and STATUS reads 1.
REQ-031 SHALL test auto-reload: ch2 LOAD=3, CTRL=0x3 -> done[2] pulses every 4 cycles; other done bits stay 0.
REQ-032 SHALL test clear collision: STATUS write 1 in the same cycle as ch1 expiry -> STATUS.EXP reads 1; a later write 1 -> reads 0.
REQ-033 SHALL test a reset mid-count: ch3 LOAD=10 armed, rst asserted after 4 cycles -> all registers read 0 and no done pulse occurs afterwards.
REQ-034 SHALL test an invalid address: write to 0x80, then read 0x80 -> read_data=0 and no channel state changes.
REQ-035 SHALL test the prescaler (with TIMER_BANK_PRESCALE_EN): PRESC=3, ch0 LOAD=1, CTRL=0x1 -> done[0] within 8 clk cycles, and never earlier than after 2 ticks.
